// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, mid-bit sampling and parity/framing checks,
// feeding a first-word-fall-through FIFO that the CPU reads through 'out' and pops with 'load'.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        RX,
  input  logic                        load,
  output logic [15:0]                 out,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1    = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
  localparam logic [15:0]   EMPTY_W   = 16'h8000;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          perr_q, perr_d, ferr_q, ferr_d;
  logic          rxs, tick, push;
  logic [15:0]   push_w;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   count_q, count_d, rem;
  logic [15:0]   out_q, out_d;
  logic          ovr_q, ovr_d, pop, full, wr_en;

  assign sync_d = {sync_q[0], RX};
  assign rxs    = sync_q[1];
  assign tick   = (cnt_q == BIT_M1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: if (!rxs) begin
        state_d = S_START;
        cnt_d   = '0;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_DATA: begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          // LSB first: each new bit enters at the top of the DATA_BITS-wide window.
          shift_d = {1'b0, shift_q[7:1]};
          shift_d[DATA_BITS-1] = rxs;
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          perr_d  = ((^shift_q) ^ rxs) != (PARITY == 1);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          if (!rxs) ferr_d = 1'b1;
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_STOP) begin
            push    = 1'b1;
            idx_d   = '0;
            state_d = ferr_d ? S_BREAK : S_IDLE;
          end
        end
      end
      S_BREAK: if (rxs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    push_w = {1'b0, ferr_d, perr_q, 5'b0, shift_q};
  end

  always_comb begin
    pop     = load && (count_q != '0);
    full    = (count_q == DEPTH_C);
    wr_en   = push && (!full || pop);
    ovr_d   = ovr_q || (push && full && !pop);
    wr_d    = wr_en ? wr_q + PW'(1) : wr_q;
    rd_d    = pop ? rd_q + PW'(1) : rd_q;
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + (PW+1)'(1);
    else if (pop && !wr_en) count_d = count_q - (PW+1)'(1);
    // Head after this edge: an older entry if one survives the pop, else the incoming word.
    rem   = pop ? count_q - (PW+1)'(1) : count_q;
    out_d = EMPTY_W;
    if (rem != '0)  out_d = mem_q[rd_d];
    else if (wr_en) out_d = push_w;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      out_q   <= EMPTY_W;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      out_q   <= out_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear && wr_en) mem_q[wr_q] <= push_w;
  end

  assign out     = out_q;
  assign count   = count_q;
  assign overrun = ovr_q;
endmodule
